// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the CPU data-side memory controller.
// Provides: mem_size_t, ctrl_state_t, is_misaligned(), lane_swap().
// Combinational helpers only; no clocked logic lives here.
package data_mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2,
    RSVD = 2'd3
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } ctrl_state_t;

  // Reserved size is always reported as misaligned.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      BYTE:    bad = 1'b0;
      HALF:    bad = off[0];
      WORD:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // RAM keeps byte offset k in bits [31-8k -: 8]; the architectural word
  // keeps it in [8k +: 8]. The mapping is a plain byte reversal both ways.
  function automatic logic [31:0] lane_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/data_mem_controller_byte_lane.sv
// mem_byte_lane: load extract/extend and sub-word store merge.
// Ports: ram_word (raw RAM word), offset, size, is_unsigned, wdata in;
//        load_data (extended load result), merge_data (RAM-order word) out.
module mem_byte_lane
  import data_mem_pkg::*;
(
  input  logic [31:0] ram_word,
  input  logic [1:0]  offset,
  input  mem_size_t   size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [31:0] arch_word;
  logic [31:0] shifted;
  logic [31:0] mask;
  logic [31:0] merged_arch;
  logic [4:0]  bit_shift;

  // Work in architectural byte order so offsets become simple shifts.
  assign arch_word = lane_swap(ram_word);
  assign bit_shift = {offset, 3'b000};
  assign shifted   = arch_word >> bit_shift;

  always_comb begin
    load_data = arch_word;
    mask      = 32'hFFFF_FFFF;
    case (size)
      BYTE: begin
        mask      = 32'h0000_00FF;
        load_data = is_unsigned ? {24'd0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      end
      HALF: begin
        mask      = 32'h0000_FFFF;
        load_data = is_unsigned ? {16'd0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        mask      = 32'hFFFF_FFFF;
        load_data = arch_word;
      end
    endcase
  end

  assign merged_arch = (arch_word & ~(mask << bit_shift)) | ((wdata & mask) << bit_shift);
  assign merge_data  = lane_swap(merged_arch);

endmodule

// File: rtl/data_mem_controller.sv
// data_mem_controller: sequences CPU data loads/stores onto a shared BRAM
// (write port + read port B). Ports: CPU request/response (data_*),
// RAM write port (ram_write_*, ram_data_in), RAM read port B (ram_*_b).
module data_mem_controller
  import data_mem_pkg::*;
#(
  parameter int RAM_A_WIDTH = 12
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   data_req,
  input  logic                   data_we,
  input  logic [1:0]             data_size,
  input  logic                   data_unsigned,
  input  logic [31:0]            data_addr,
  input  logic [31:0]            data_wdata,
  output logic                   data_ready,
  output logic                   data_done,
  output logic                   data_fault,
  output logic [31:0]            data_rdata,
  output logic [RAM_A_WIDTH-1:0] ram_write_address,
  output logic [31:0]            ram_data_in,
  output logic                   ram_write_enable,
  output logic [RAM_A_WIDTH-1:0] ram_read_address_b,
  input  logic [31:0]            ram_data_out_b
);

  ctrl_state_t state, state_nxt;

  logic [RAM_A_WIDTH-1:0] addr_q;
  logic [1:0]             off_q;
  mem_size_t              size_q;
  logic                   uns_q;
  logic [31:0]            wdata_q;
  logic                   fault_q;
  logic [31:0]            wword_q;
  logic [31:0]            rdata_q;

  mem_size_t   req_size;
  logic        req_misaligned;
  logic        accept;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  // Upper address bits wrap and are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^data_addr[31:RAM_A_WIDTH+2];

  assign req_size       = mem_size_t'(data_size);
  assign req_misaligned = is_misaligned(req_size, data_addr[1:0]);
  assign accept         = (state == IDLE) && data_req;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    data_ready       = 1'b0;
    data_done        = 1'b0;
    data_fault       = 1'b0;
    ram_write_enable = 1'b0;
    case (state)
      IDLE: begin
        data_ready = 1'b1;
        if (data_req) begin
          if (req_misaligned)    state_nxt = DONE;
          else if (!data_we)     state_nxt = LOAD;
          else if (req_size == WORD) state_nxt = WRITE;
          else                   state_nxt = MERGE;
        end
      end
      LOAD:  state_nxt = DONE;
      MERGE: state_nxt = WRITE;
      WRITE: begin
        ram_write_enable = 1'b1;
        state_nxt        = DONE;
      end
      DONE: begin
        data_done  = 1'b1;
        data_fault = fault_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      off_q   <= 2'b00;
      size_q  <= BYTE;
      uns_q   <= 1'b0;
      wdata_q <= 32'd0;
      fault_q <= 1'b0;
      wword_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      if (accept) begin
        addr_q  <= data_addr[RAM_A_WIDTH+1:2];
        off_q   <= data_addr[1:0];
        size_q  <= req_size;
        uns_q   <= data_unsigned;
        wdata_q <= data_wdata;
        fault_q <= req_misaligned;
        // Word stores skip the read: the whole word is replaced.
        wword_q <= lane_swap(data_wdata);
      end
      if (state == LOAD)  rdata_q <= load_data;
      if (state == MERGE) wword_q <= merge_data;
    end
  end

  // In IDLE the read is launched from the live request so LOAD/MERGE see
  // RAM data one cycle after accept; afterwards hold the latched index.
  assign ram_read_address_b = (state == IDLE) ? data_addr[RAM_A_WIDTH+1:2] : addr_q;
  assign ram_write_address  = addr_q;
  assign ram_data_in        = wword_q;
  assign data_rdata         = rdata_q;

  mem_byte_lane u_lane (
    .ram_word    (ram_data_out_b),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench for data_mem_controller with a behavioural BRAM model.
// Checks reset values, load formatting, store merges, latencies, faults,
// address wrap and reset during a sub-word store.
module tb_data_mem_controller;

  logic        clock;
  logic        reset_n;
  logic        data_req;
  logic        data_we;
  logic [1:0]  data_size;
  logic        data_unsigned;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ready;
  logic        data_done;
  logic        data_fault;
  logic [31:0] data_rdata;
  logic [11:0] ram_write_address;
  logic [31:0] ram_data_in;
  logic        ram_write_enable;
  logic [11:0] ram_read_address_b;
  logic [31:0] ram_data_out_b;

  logic [31:0] mem [0:4095];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [31:0] pl_dat;

  int checks;
  int failures;

  data_mem_controller #(.RAM_A_WIDTH(12)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .data_req           (data_req),
    .data_we            (data_we),
    .data_size          (data_size),
    .data_unsigned      (data_unsigned),
    .data_addr          (data_addr),
    .data_wdata         (data_wdata),
    .data_ready         (data_ready),
    .data_done          (data_done),
    .data_fault         (data_fault),
    .data_rdata         (data_rdata),
    .ram_write_address  (ram_write_address),
    .ram_data_in        (ram_data_in),
    .ram_write_enable   (ram_write_enable),
    .ram_read_address_b (ram_read_address_b),
    .ram_data_out_b     (ram_data_out_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // BRAM: one write port, registered read on port B; preload shares the write port.
  always @(posedge clock) begin
    if (pl_en)                 mem[pl_addr] <= pl_dat;
    else if (ram_write_enable) mem[ram_write_address] <= ram_data_in;
    ram_data_out_b <= mem[ram_read_address_b];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clock);
    pl_en = 1'b1; pl_addr = a; pl_dat = d;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  // Issues one request; latencies are counted in cycles after the accept cycle.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int done_at, output int we_at,
                        output logic [31:0] waddr, output logic [31:0] wdat,
                        output logic flt);
    @(negedge clock);
    chk("ready_before_req", {31'd0, data_ready}, 32'd1);
    data_req = 1'b1; data_we = we; data_size = size; data_unsigned = uns;
    data_addr = addr; data_wdata = wdata;
    @(posedge clock);
    done_at = -1; we_at = -1; waddr = 32'd0; wdat = 32'd0; flt = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      data_req = 1'b0;
      if (ram_write_enable && we_at < 0) begin
        we_at = n;
        waddr = {20'd0, ram_write_address};
        wdat  = ram_data_in;
      end
      if (data_done) begin
        done_at = n;
        flt     = data_fault;
        break;
      end
    end
    if (done_at < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  int          d_at, w_at;
  logic [31:0] w_addr, w_dat;
  logic        flt;

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0; data_req = 1'b0; data_we = 1'b0; data_size = 2'd0;
    data_unsigned = 1'b0; data_addr = 32'd0; data_wdata = 32'd0;
    pl_en = 1'b0; pl_addr = 12'd0; pl_dat = 32'd0;

    #12;
    chk("rst_we",    {31'd0, ram_write_enable}, 32'd0);
    chk("rst_done",  {31'd0, data_done},        32'd0);
    chk("rst_fault", {31'd0, data_fault},       32'd0);
    chk("rst_rdata", data_rdata,                32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_rst", {31'd0, data_ready}, 32'd1);

    preload(12'd0, 32'h11223344);
    preload(12'd1, 32'h80FF7F01);

    // lw 0
    access(1'b0, 2'd2, 1'b0, 32'd0, 32'd0, d_at, w_at, w_addr, w_dat, flt);
    chk("lw0_data",  data_rdata, 32'h44332211);
    chk("lw0_lat",   d_at,       32'd2);
    chk("lw0_fault", {31'd0, flt}, 32'd0);
    chk("lw0_nowr",  w_at,       32'hFFFF_FFFF);

    access(1'b0, 2'd0, 1'b1, 32'd1, 32'd0, d_at, w_at, w_addr, w_dat, flt);
    chk("lbu1_data", data_rdata, 32'h00000022);
    chk("lbu1_lat",  d_at,       32'd2);
    access(1'b0, 2'd1, 1'b0, 32'd2, 32'd0, d_at, w_at, w_addr, w_dat, flt);
    chk("lh2_data",  data_rdata, 32'h00004433);
    access(1'b0, 2'd1, 1'b0, 32'd4, 32'd0, d_at, w_at, w_addr, w_dat, flt);
    chk("lh4_data",  data_rdata, 32'hFFFFFF80);
    access(1'b0, 2'd1, 1'b1, 32'd4, 32'd0, d_at, w_at, w_addr, w_dat, flt);
    chk("lhu4_data", data_rdata, 32'h0000FF80);
    access(1'b0, 2'd0, 1'b0, 32'd5, 32'd0, d_at, w_at, w_addr, w_dat, flt);
    chk("lb5_data",  data_rdata, 32'hFFFFFFFF);
    access(1'b0, 2'd0, 1'b1, 32'd6, 32'd0, d_at, w_at, w_addr, w_dat, flt);
    chk("lbu6_data", data_rdata, 32'h0000007F);

    // Upper address bits wrap onto word 0.
    access(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'd0, d_at, w_at, w_addr, w_dat, flt);
    chk("wrap_data", data_rdata, 32'h44332211);

    // sb 0xAB to addr 5
    access(1'b1, 2'd0, 1'b0, 32'd5, 32'h000000AB, d_at, w_at, w_addr, w_dat, flt);
    chk("sb5_wr_at",  w_at,   32'd2);
    chk("sb5_waddr",  w_addr, 32'd1);
    chk("sb5_wdat",   w_dat,  32'h80AB7F01);
    chk("sb5_lat",    d_at,   32'd3);
    chk("sb5_fault",  {31'd0, flt}, 32'd0);
    chk("sb5_rdata_held", data_rdata, 32'h44332211);
    chk("sb5_mem",    mem[1], 32'h80AB7F01);

    // misaligned sw addr 6
    access(1'b1, 2'd2, 1'b0, 32'd6, 32'hDEADBEEF, d_at, w_at, w_addr, w_dat, flt);
    chk("sw6_lat",   d_at, 32'd1);
    chk("sw6_fault", {31'd0, flt}, 32'd1);
    chk("sw6_nowr",  w_at, 32'hFFFF_FFFF);
    chk("sw6_rdata", data_rdata, 32'h44332211);
    chk("sw6_mem",   mem[1], 32'h80AB7F01);

    // reserved size and odd halfword load also fault
    access(1'b0, 2'd3, 1'b0, 32'd0, 32'd0, d_at, w_at, w_addr, w_dat, flt);
    chk("rsvd_fault", {31'd0, flt}, 32'd1);
    chk("rsvd_lat",   d_at, 32'd1);
    access(1'b0, 2'd1, 1'b0, 32'd1, 32'd0, d_at, w_at, w_addr, w_dat, flt);
    chk("lh1_fault",  {31'd0, flt}, 32'd1);
    chk("lh1_rdata",  data_rdata, 32'h44332211);

    // sw addr 8
    access(1'b1, 2'd2, 1'b0, 32'd8, 32'h12345678, d_at, w_at, w_addr, w_dat, flt);
    chk("sw8_wr_at", w_at,   32'd1);
    chk("sw8_waddr", w_addr, 32'd2);
    chk("sw8_wdat",  w_dat,  32'h78563412);
    chk("sw8_lat",   d_at,   32'd2);
    access(1'b0, 2'd2, 1'b0, 32'd8, 32'd0, d_at, w_at, w_addr, w_dat, flt);
    chk("lw8_data",  data_rdata, 32'h12345678);

    // sh 0xBEEF to addr 10
    access(1'b1, 2'd1, 1'b0, 32'd10, 32'hFFFFBEEF, d_at, w_at, w_addr, w_dat, flt);
    chk("sh10_wdat", w_dat, 32'h7856EFBE);
    chk("sh10_wr_at", w_at, 32'd2);
    access(1'b0, 2'd2, 1'b0, 32'd8, 32'd0, d_at, w_at, w_addr, w_dat, flt);
    chk("lw8b_data", data_rdata, 32'hBEEF5678);

    // Reset while a byte store sits in MERGE.
    @(negedge clock);
    data_req = 1'b1; data_we = 1'b1; data_size = 2'd0; data_unsigned = 1'b0;
    data_addr = 32'd5; data_wdata = 32'h000000CD;
    @(posedge clock);
    @(negedge clock);
    data_req = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("mrst_we",    {31'd0, ram_write_enable}, 32'd0);
    chk("mrst_done",  {31'd0, data_done},        32'd0);
    chk("mrst_fault", {31'd0, data_fault},       32'd0);
    chk("mrst_rdata", data_rdata,                32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    chk("mrst_mem", mem[1], 32'h80AB7F01);
    access(1'b0, 2'd2, 1'b0, 32'd4, 32'd0, d_at, w_at, w_addr, w_dat, flt);
    chk("mrst_load", data_rdata, 32'h017FAB80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_controller.md
Name: data_mem_controller

Overview:
- Sequences all CPU data-side load/store traffic onto the shared 32-bit single-write, dual-read block RAM.
- The RAM has a 1-cycle registered read; this block owns its write port and read port B. Read port A stays with instruction fetch.
- Handles byte, halfword and word accesses, sign/zero extension, and read-modify-write for sub-word stores.
- Detects misaligned accesses and reports them as faults.

Parameters:
- RAM_A_WIDTH, 12, word-address width of the RAM (depth 2**RAM_A_WIDTH words).

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- data_req  in  1  request strobe, sampled when data_ready=1
- data_we  in  1  1=store, 0=load
- data_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as misaligned)
- data_unsigned  in  1  zero-extend loads when 1
- data_addr  in  32  byte address
- data_wdata  in  32  store data, value in low bits
- data_ready  out  1  controller idle, request accepted this cycle
- data_done  out  1  one-cycle completion pulse
- data_fault  out  1  valid with data_done, misaligned/reserved access
- data_rdata  out  32  load result, valid with data_done, held until next done
- ram_write_address  out  RAM_A_WIDTH  to RAM write port
- ram_data_in  out  32  to RAM write port
- ram_write_enable  out  1  to RAM write port
- ram_read_address_b  out  RAM_A_WIDTH  to RAM read port B
- ram_data_out_b  in  32  from RAM read port B, valid 1 cycle after address

Behaviour:
- Reset is async, active-low, and fully described here; no other reset behaviour is required.
  - Asserting reset_n=0 forces state IDLE immediately.
  - Outputs during and after reset: ram_write_enable=0, data_done=0, data_fault=0, data_rdata=0; data_ready=1 after release.
  - Reset mid-operation abandons the access; the RAM is written only if WRITE was already reached on a clock edge.
- Word index = data_addr[RAM_A_WIDTH+1:2]. Upper address bits are ignored (wrap).
- Lane map: byte offset k is stored at RAM bits [31-8k -: 8].
  - Architectural word = {b3,b2,b1,b0}.
  - Halfword at offset k = {b(k+1),bk}.
- Misaligned conditions: half with addr[0]=1; word with addr[1:0]!=0; size=3.
- States:
  - IDLE: data_ready=1; ram_read_address_b driven combinationally from data_addr.
  - On accept:
    - misaligned -> DONE with fault
    - load -> LOAD
    - word store -> WRITE (merged word = byte-lane-swapped wdata)
    - byte/half store -> MERGE
  - LOAD: format ram_data_out_b (extract, extend) into data_rdata register -> DONE.
  - MERGE: replace only the addressed lanes of ram_data_out_b with the store data, register the result -> WRITE.
  - WRITE: ram_write_enable=1, address and data from the registered request -> DONE.
  - DONE: data_done=1; data_fault per latched flag; data_rdata unchanged by stores and faults -> IDLE.
- Latency from accept cycle T:
  - load: done at T+2
  - word store: write at T+1, done at T+2
  - sub-word store: write at T+2, done at T+3
  - fault: done at T+1
- data_ready=0 outside IDLE; data_req is ignored there.
- ram_write_enable=1 only in WRITE, never on a fault.

Decomposition:
- Package data_mem_pkg:
  - enum mem_size_t {BYTE, HALF, WORD, RSVD}
  - enum ctrl_state_t {IDLE, LOAD, MERGE, WRITE, DONE}
  - functions is_misaligned() and lane_swap()
- Sub-module mem_byte_lane (combinational):
  - load extract and extend
  - store merge from word, offset, size and wdata

Test Plan:
- Preload word0=32'h11223344. Load word addr 0 -> data_rdata=32'h44332211, done at T+2.
- Same RAM. lbu addr 1 -> 32'h00000022. lh addr 2 -> 32'h00004433.
- Preload word1=32'h80FF7F01. lh signed addr 4 -> 32'hFFFFFF80. lbu addr 6 -> 32'h0000007F.
- Store byte 32'h000000AB to addr 5 with word1=32'h80FF7F01 -> RAM write 32'h80AB7F01 at word 1 on T+2, done at T+3.
- Store word addr 6 -> done at T+1 with data_fault=1, no ram_write_enable, data_rdata unchanged.
- Sub-word store, reset_n=0 asserted during MERGE -> outputs reset immediately, word 1 unchanged, next load returns the original value.
